lfsr_range_sampler: RTL and testbench

LFSR_RANGE_SAMPLER -- requirements
Module: lfsr_range_sampler

---
 rtl/lfsr_range_sampler.sv | 148 ++++++++++++++
 tb/tb_lfsr_range_sampler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_sampler.sv
// rtl/lfsr_range_sampler.sv - draws an unbiased value in 0..N-1 from an upstream LFSR by mask-and-reject
//
// Ports:
//   i_Clk          clock, rising edge
//   i_Rst          asynchronous active-low reset
//   i_Req          request one bounded value (sampled in IDLE only)
//   i_Limit        exclusive upper bound N, latched on acceptance
//   i_LFSR_Data    current upstream LFSR output
//   o_LFSR_Enable  advance strobe to the upstream LFSR (one per draw)
//   o_Rand         result, always < N
//   o_Valid        o_Rand/o_Tries/o_Fallback are valid
//   i_Ready        consumer accepts the result
//   o_Busy         high whenever not IDLE
//   o_Fallback     result came from the reduce-by-N path after MAX_TRIES rejections
//   o_Tries        number of LFSR samples consumed

module lfsr_range_sampler #(
    parameter int WIDTH     = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Req,
    input  logic [WIDTH-1:0] i_Limit,
    input  logic [WIDTH-1:0] i_LFSR_Data,
    output logic             o_LFSR_Enable,
    output logic [WIDTH-1:0] o_Rand,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic             o_Busy,
    output logic             o_Fallback,
    output logic [3:0]       o_Tries
);

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MASK = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic [3:0]       tries_q, tries_d;
    logic             fb_q, fb_d;

    logic [WIDTH-1:0] limit_m1;
    logic [WIDTH-1:0] mask_calc;
    logic [WIDTH-1:0] candidate;
    logic [3:0]       tries_inc;

    // Smallest all-ones mask covering N-1: bit i is set when any bit at or
    // above i is set in N-1. Keeps mask < 2N so the fallback subtraction
    // always lands inside 0..N-1.
    assign limit_m1 = limit_q - ONE;

    always_comb begin
        mask_calc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_calc[i] = |(limit_m1 >> i);
        end
    end

    assign candidate = i_LFSR_Data & mask_q;
    assign tries_inc = tries_q + 4'd1;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= IDLE;
            limit_q <= '0;
            mask_q  <= '0;
            rand_q  <= '0;
            tries_q <= '0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            mask_q  <= mask_d;
            rand_q  <= rand_d;
            tries_q <= tries_d;
            fb_q    <= fb_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        limit_d       = limit_q;
        mask_d        = mask_q;
        rand_d        = rand_q;
        tries_d       = tries_q;
        fb_d          = fb_q;
        o_LFSR_Enable = 1'b0;
        o_Valid       = 1'b0;
        o_Busy        = 1'b1;

        case (state_q)
            IDLE: begin
                o_Busy = 1'b0;
                if (i_Req) begin
                    limit_d = i_Limit;
                    tries_d = 4'd0;
                    fb_d    = 1'b0;
                    if (i_Limit <= ONE) begin
                        // Only 0 is a legal answer; no LFSR sample needed.
                        rand_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = MASK;
                    end
                end
            end
            MASK: begin
                mask_d  = mask_calc;
                state_d = DRAW;
            end
            DRAW: begin
                o_LFSR_Enable = 1'b1;
                tries_d       = tries_inc;
                if (candidate < limit_q) begin
                    rand_d  = candidate;
                    fb_d    = 1'b0;
                    state_d = DONE;
                end else if (tries_inc == TRIES_MAX) begin
                    rand_d  = candidate - limit_q;
                    fb_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_Valid = 1'b1;
                if (i_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_Rand     = rand_q;
    assign o_Tries    = tries_q;
    assign o_Fallback = fb_q;

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// tb/tb_lfsr_range_sampler.sv - scoreboard bench for lfsr_range_sampler

module tb_lfsr_range_sampler;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic        i_Req = 1'b0;
    logic [15:0] i_Limit = '0;
    logic [15:0] i_LFSR_Data;
    logic        o_LFSR_Enable;
    logic [15:0] o_Rand;
    logic        o_Valid;
    logic        i_Ready = 1'b1;
    logic        o_Busy;
    logic        o_Fallback;
    logic [3:0]  o_Tries;

    lfsr_range_sampler #(.WIDTH(16), .MAX_TRIES(8)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Limit(i_Limit),
        .i_LFSR_Data(i_LFSR_Data), .o_LFSR_Enable(o_LFSR_Enable),
        .o_Rand(o_Rand), .o_Valid(o_Valid), .i_Ready(i_Ready),
        .o_Busy(o_Busy), .o_Fallback(o_Fallback), .o_Tries(o_Tries)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [15:0] rand_v;
        int          tries;
        logic        fb;
        int          lat;
        longint      t0;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    // Upstream LFSR stand-in: a short table stepped by each enable strobe.
    logic [15:0] tab [8];
    int          adv = 0;
    int          base = 0;
    int          ofs;
    always_comb ofs = ((adv - base) > 7) ? 7 : (adv - base);
    assign i_LFSR_Data = tab[ofs[2:0]];
    always @(posedge i_Clk) if (o_LFSR_Enable) adv <= adv + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        tab[0] = a;
        tab[1] = b;
        for (int i = 2; i < 8; i++) tab[i] = c;
        base = adv;
    endtask

    // Monitor: pops one expectation per o_Valid rising and counts enable pulses.
    int   en_cnt = 0;
    int   en_runs = 0;
    logic prev_en = 1'b0;
    logic prev_valid = 1'b0;
    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            en_cnt = 0;
            en_runs = 0;
            prev_en = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (o_LFSR_Enable) begin
                en_cnt++;
                if (!prev_en) en_runs++;
            end
            prev_en = o_LFSR_Enable;
            if (o_Valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got o_Rand %0h with empty scoreboard", o_Rand);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rand", 32'(o_Rand), 32'(e.rand_v));
                    check("tries", 32'(o_Tries), 32'(e.tries));
                    check("fallback", 32'(o_Fallback), 32'(e.fb));
                    check("latency", 32'(($time - e.t0 + 5) / 10), 32'(e.lat));
                    check("enable_count", 32'(en_cnt), 32'(e.tries));
                    check("enable_runs", 32'(en_runs), (e.tries > 0) ? 32'd1 : 32'd0);
                end
                en_cnt = 0;
                en_runs = 0;
                done_cnt++;
            end
            prev_valid = o_Valid;
        end
    end

    task automatic push_exp(input logic [15:0] r, input int tries, input logic fb, input int lat);
        exp_t e;
        e.rand_v = r;
        e.tries  = tries;
        e.fb     = fb;
        e.lat    = lat;
        e.t0     = longint'($time);
        sb.push_back(e);
    endtask

    task automatic wait_done(input int start, input string name);
        int k;
        k = 0;
        while (done_cnt == start && k < 40) begin
            @(negedge i_Clk);
            k++;
        end
        check(name, (done_cnt != start) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // One request with i_Ready high; i_Limit is scrambled right after acceptance.
    task automatic issue(input logic [15:0] n, input logic [15:0] r, input int tries, input logic fb);
        int start;
        int lat;
        start = done_cnt;
        lat = (n <= 16'd1) ? 1 : 2 + tries;
        @(negedge i_Clk);
        i_Limit = n;
        i_Req = 1'b1;
        @(posedge i_Clk);
        push_exp(r, tries, fb, lat);
        @(negedge i_Clk);
        i_Req = 1'b0;
        i_Limit = 16'hDEAD;
        wait_done(start, "done_timeout");
        @(negedge i_Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        load(16'h0000, 16'h0000, 16'h0000);

        // Reset held with a pending request.
        i_Req = 1'b1;
        i_Limit = 16'd10;
        repeat (2) begin
            @(negedge i_Clk);
            check("rst_valid", 32'(o_Valid), 32'd0);
            check("rst_busy", 32'(o_Busy), 32'd0);
            check("rst_enable", 32'(o_LFSR_Enable), 32'd0);
            check("rst_rand", 32'(o_Rand), 32'd0);
            check("rst_tries", 32'(o_Tries), 32'd0);
            check("rst_fallback", 32'(o_Fallback), 32'd0);
        end
        i_Req = 1'b0;
        i_Rst = 1'b1;

        load(16'h1234, 16'h0000, 16'h0000);
        issue(16'd10, 16'd4, 1, 1'b0);
        load(16'h000F, 16'h000C, 16'h0007);
        issue(16'd10, 16'd7, 3, 1'b0);
        load(16'hFFFF, 16'hFFFF, 16'hFFFF);
        issue(16'd9, 16'd6, 8, 1'b1);
        issue(16'd1, 16'd0, 0, 1'b0);
        issue(16'd0, 16'd0, 0, 1'b0);
        load(16'hFFFF, 16'hFFFE, 16'h0000);
        issue(16'hFFFF, 16'hFFFE, 2, 1'b0);
        load(16'hFFFF, 16'h0000, 16'h0000);
        issue(16'h8000, 16'h7FFF, 1, 1'b0);
        load(16'h0003, 16'h0002, 16'h0000);
        issue(16'd3, 16'd2, 2, 1'b0);

        // Backpressure: result held, extra request ignored.
        load(16'h1234, 16'h0000, 16'h0000);
        i_Ready = 1'b0;
        start = done_cnt;
        @(negedge i_Clk);
        i_Limit = 16'd10;
        i_Req = 1'b1;
        @(posedge i_Clk);
        push_exp(16'd4, 1, 1'b0, 3);
        @(negedge i_Clk);
        i_Req = 1'b0;
        wait_done(start, "bp_timeout");
        i_Req = 1'b1;
        i_Limit = 16'd3;
        repeat (5) begin
            @(negedge i_Clk);
            check("bp_valid", 32'(o_Valid), 32'd1);
            check("bp_rand", 32'(o_Rand), 32'd4);
            check("bp_tries", 32'(o_Tries), 32'd1);
        end
        i_Req = 1'b0;
        i_Ready = 1'b1;
        repeat (3) begin
            @(negedge i_Clk);
            check("bp_idle_busy", 32'(o_Busy), 32'd0);
            check("bp_idle_valid", 32'(o_Valid), 32'd0);
        end

        // Abort during DRAW.
        load(16'h000F, 16'h000F, 16'h000F);
        start = done_cnt;
        @(negedge i_Clk);
        i_Limit = 16'd10;
        i_Req = 1'b1;
        @(negedge i_Clk);
        i_Req = 1'b0;
        repeat (2) @(negedge i_Clk);
        check("abort_in_draw", 32'(o_LFSR_Enable), 32'd1);
        #1 i_Rst = 1'b0;
        #1;
        check("abort_busy", 32'(o_Busy), 32'd0);
        check("abort_valid", 32'(o_Valid), 32'd0);
        check("abort_enable", 32'(o_LFSR_Enable), 32'd0);
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (4) begin
            @(negedge i_Clk);
            check("abort_idle_busy", 32'(o_Busy), 32'd0);
            check("abort_no_valid", 32'(o_Valid), 32'd0);
        end
        check("abort_no_result", 32'(done_cnt), 32'(start));

        // Back to normal after abort.
        load(16'h1234, 16'h0000, 16'h0000);
        issue(16'd10, 16'd4, 1, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
